// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// It sits downstream of the parking-meter counter. Each digit owns a slot of
// DIGIT_DIV clock cycles. The first GUARD cycles of every slot keep all anodes
// off, so the previous digit's segments do not ghost onto the next digit.
//
// The BCD value is copied into a shadow frame only when the scan wraps from
// digit 3 back to digit 0. A full scan therefore always shows one consistent
// value.
//
// Parameters:
//   DIGIT_DIV     clock cycles per digit slot (>= 4)
//   GUARD         dark cycles at the start of each slot (1 <= GUARD < DIGIT_DIV)
//   DP_MASK       per-digit decimal-point enable, bit i = digit i, 1 = lit
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   bcd_value     four BCD nibbles, [3:0] = digit 0 (units)
//   flash_slow    blanks the whole display while high
//   flash_fast    blanks the whole display while high
//   blank_leading 1 = suppress leading zeros (digit 0 is always shown)
//   an            anode enables, active low, bit i = digit i
//   seg           segments {g,f,e,d,c,b,a}, active low
//   dp            decimal point, active low
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int         DIGIT_DIV = 50000,
  parameter int         GUARD     = 16,
  parameter logic [3:0] DP_MASK   = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_value,
  input  logic        flash_slow,
  input  logic        flash_fast,
  input  logic        blank_leading,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DivW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(DIGIT_DIV - 1);
  localparam logic [DivW-1:0] GuardVal = DivW'(GUARD);

  logic [DivW-1:0] r_divCnt;
  logic [1:0]      r_digit;
  logic [15:0]     r_frame;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_slotEnd;
  logic            w_blank;
  logic            w_suppress;
  logic            w_lit;
  logic [3:0]      w_nibble;
  logic [6:0]      w_decode;
  logic [3:0]      w_anNext;
  logic [6:0]      w_segNext;
  logic            w_dpNext;

  assign w_slotEnd = (r_divCnt == DivLast);
  assign w_blank   = flash_slow | flash_fast;

  // Slot counter, digit index and shadow frame. The frame reloads only on the
  // 3->0 wrap. Mid-scan changes to bcd_value wait for the next full frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divCnt <= '0;
      r_digit  <= 2'd0;
      r_frame  <= 16'h0000;
    end else if (w_slotEnd) begin
      r_divCnt <= '0;
      r_digit  <= r_digit + 2'd1;
      if (r_digit == 2'd3) begin
        r_frame <= bcd_value;
      end
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // Select the current digit's nibble. Work out leading-zero suppression:
  // digit i is hidden when every nibble from i upward is zero.
  always_comb begin
    w_nibble   = r_frame[3:0];
    w_suppress = 1'b0;
    case (r_digit)
      2'd0: begin
        w_nibble   = r_frame[3:0];
        w_suppress = 1'b0;
      end
      2'd1: begin
        w_nibble   = r_frame[7:4];
        w_suppress = blank_leading && (r_frame[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble   = r_frame[11:8];
        w_suppress = blank_leading && (r_frame[15:8] == 8'h00);
      end
      default: begin
        w_nibble   = r_frame[15:12];
        w_suppress = blank_leading && (r_frame[15:12] == 4'h0);
      end
    endcase
  end

  // BCD to active-low segment pattern. Non-BCD codes show a dash.
  always_comb begin
    w_decode = 7'b0111111;
    case (w_nibble)
      4'd0:    w_decode = 7'b1000000;
      4'd1:    w_decode = 7'b1111001;
      4'd2:    w_decode = 7'b0100100;
      4'd3:    w_decode = 7'b0110000;
      4'd4:    w_decode = 7'b0011001;
      4'd5:    w_decode = 7'b0010010;
      4'd6:    w_decode = 7'b0000010;
      4'd7:    w_decode = 7'b1111000;
      4'd8:    w_decode = 7'b0000000;
      4'd9:    w_decode = 7'b0010000;
      default: w_decode = 7'b0111111;
    endcase
  end

  // A digit lights only past the guard interval, when not flashing and not
  // suppressed. Otherwise everything stays dark. At most one anode can be low.
  assign w_lit = (r_divCnt >= GuardVal) && !w_blank && !w_suppress;

  always_comb begin
    w_anNext  = 4'b1111;
    w_segNext = 7'b1111111;
    w_dpNext  = 1'b1;
    if (w_lit) begin
      w_anNext[r_digit] = 1'b0;
      w_segNext         = w_decode;
      w_dpNext          = ~DP_MASK[r_digit];
    end
  end

  // Output registers. Reset darkens the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_anNext;
      r_seg <= w_segNext;
      r_dp  <= w_dpNext;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the parking-meter counter. It takes the counter's packed 4-digit BCD value and its two flash outputs, and drives a 4-digit common-anode seven-segment display by time-multiplexing. Features:
- Tear-free frame latching of the BCD value.
- Anti-ghosting guard interval at each digit change.
- Optional leading-zero blanking.
- Flash blanking driven by the counter's `flash_slow` / `flash_fast` toggles.

## Interface
Parameters:
- `DIGIT_DIV`, default 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz). Legal range ≥ 4.
- `GUARD`, default 16: cycles at the start of each slot with all anodes off. Legal range 1 ≤ GUARD < DIGIT_DIV.
- `DP_MASK`, default 4'b0000: per-digit decimal-point enable (1 = lit). Bit i corresponds to digit i.

Ports:
- `clk` input 1: system clock (50 MHz).
- `reset` input 1: asynchronous, active-high reset.
- `bcd_value` input 16: four BCD nibbles; [3:0] is digit 0 (units), [15:12] is digit 3.
- `flash_slow` input 1: when high, the display is blanked.
- `flash_fast` input 1: when high, the display is blanked.
- `blank_leading` input 1: 1 = suppress leading zeros.
- `an` output 4: anode enables, active low; bit i drives digit i.
- `seg` output 7: segments {g,f,e,d,c,b,a}, active low.
- `dp` output 1: decimal point, active low.

## Operation
Internal state:
- `div_cnt`: 0..DIGIT_DIV-1.
- Digit index `d`: 0..3.
- `frame`: 16-bit shadow copy of `bcd_value`.

Counting and frame latching:
- Each cycle, `div_cnt` increments.
- When `div_cnt == DIGIT_DIV-1`, `div_cnt` goes to 0 and `d` goes to d+1. `d` wraps from 3 to 0.
- `frame` loads `bcd_value` only on the 3→0 wrap. A full scan therefore always shows one consistent value. Changes to `bcd_value` mid-frame are ignored until the next wrap.

Blanking conditions:
- `blank = flash_slow | flash_fast`. It is evaluated every cycle, not only at slot boundaries.
- Leading-zero suppression (`blank_leading=1`): digit i is suppressed if i > 0 and all `frame` nibbles j ≥ i are 0. Digit 0 is never suppressed. Example: 0x0050 suppresses digits 3 and 2.

Output values:
- Anode: `an` = ~(1<<d) only when `div_cnt >= GUARD`, `!blank` and digit d is not suppressed. Otherwise `an` = 4'b1111.
- `seg` during the guard interval, when blanked, or when digit d is suppressed: 7'b1111111.
- `seg` otherwise: decode of nibble d of `frame`:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - A–F (invalid BCD): 0111111, a dash.
- `dp` = ~DP_MASK[d] whenever the anode for d is active; otherwise 1.

## Timing
- Reset (asynchronous assert, synchronous release to next clk edge):
  - `div_cnt`=0, `d`=0, `frame`=0.
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
- All outputs are registered, with 1-cycle latency. Outputs at edge t+1 reflect `div_cnt`, `d`, `frame`, `blank_leading`, `flash_*` as sampled at edge t.
- The first lit digit after reset release is digit 0, with `an`=1110 appearing at cycle GUARD+1. It displays `frame`=0, i.e. "0", because the first `frame` load happens only at the first wrap.
- A full scan takes 4×DIGIT_DIV cycles. The new `frame` is visible from the first lit cycle of the following digit-0 slot.
- Flash assert or deassert mid-slot affects `an`/`seg` exactly 1 cycle later. The slot counters are not disturbed.
- Reset mid-scan: all outputs go dark immediately (asynchronously) and the scan restarts at digit 0.
- At no cycle may `an` have more than one bit low.

## Test plan
Benches use DIGIT_DIV=8, GUARD=2, DP_MASK=4'b0100.
1. Reset hold, then release: `an`=1111 and `seg`=1111111 for 3 cycles after release. `an`=1110, `seg`=1000000 ("0") follows, lasting 6 cycles.
2. `bcd_value`=16'h1234, flash=0, `blank_leading`=0, run 2 frames. Second frame shows, in order:
   - d0: `an`=1110, `seg`=0011001
   - d1: `an`=1101, `seg`=0110000
   - d2: `an`=1011, `seg`=0100100, `dp`=0
   - d3: `an`=0111, `seg`=1111001
   
   Each digit lit for 6 cycles and dark for 2. The one-hot check holds on every cycle.
3. `blank_leading`=1:
   - `bcd_value`=16'h0050: digits 3 and 2 are never lit; d1 shows 0010010, d0 shows 1000000.
   - `bcd_value`=0: only d0 is lit, showing "0".
4. During the d1 slot, change `bcd_value` from 16'h1234 to 16'h9999: the remaining d2/d3 slots still show 2 and 1, and the next d0 shows 0010000.
5. Assert `flash_fast`=1 mid-slot: `an`=1111 from the next cycle. Deassert: the current digit relights 1 cycle later, slot timing unchanged. Repeat with `flash_slow`.
6. `bcd_value`=16'h00A0, `blank_leading`=0: d1 shows the dash 0111111. Assert `reset` mid-d1 without a clock edge: `an`=1111 immediately, and after release the scan restarts at d0.
